cla_nibble_serial_adder: RTL

//  Multi-cycle WIDTH-bit adder controller that wraps the team's 4-bit carry-lookahead slice.
//  - Latches two WIDTH-bit operands and drives one 4-bit nibble per cycle, LSB nibble first, into an external 4-bit CLA.
//  - Captures that CLA's sum/cout, chains the carry, and assembles the full result.
//  - Sits directly upstream (operand feed) and downstream (result capture) of the CLA instance.

---
 rtl/cla_nibble_serial_adder.sv | 120 ++++++++++++
 1 files changed

// File: rtl/cla_nibble_serial_adder.sv
// cla_nibble_serial_adder
// Multi-cycle WIDTH-bit adder controller around an external 4-bit
// carry-lookahead slice. Operands are latched on an accepted start, fed to
// the slice one nibble per cycle (LSB first), and the slice's sum/carry are
// captured back into an assembled result with a chained carry.
module cla_nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             result_cout,
  output logic [3:0]       cla_a,
  output logic [3:0]       cla_b,
  output logic             cla_cin,
  input  logic [3:0]       cla_sum,
  input  logic             cla_cout
);

  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = $clog2(NIB);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry;
  logic [IDXW-1:0]  idx;
  logic [IDXW+1:0]  bit_base;
  logic             accept;
  logic             last_step;

  // Bit offset of the nibble currently being processed.
  assign bit_base  = {idx, 2'b00};
  // A new add may start from IDLE or from the single DONE cycle, never mid-run.
  assign accept    = start && (state != S_RUN);
  // The step that captures the most significant nibble.
  assign last_step = (state == S_RUN) && (idx == LAST_IDX);

  // State register; a synchronous reset aborts any add in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: run exactly NIB steps, then show one DONE cycle.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept) state_next = S_RUN;
      S_RUN:   if (last_step) state_next = S_DONE;
      S_DONE:  state_next = accept ? S_RUN : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath: latch operands on accept, then capture one slice result per step.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg       <= '0;
      b_reg       <= '0;
      carry       <= 1'b0;
      idx         <= '0;
      result      <= '0;
      result_cout <= 1'b0;
    end else if (accept) begin
      a_reg       <= op_a;
      b_reg       <= op_b;
      carry       <= op_cin;
      idx         <= '0;
      result      <= '0;
      result_cout <= 1'b0;
    end else if (state == S_RUN) begin
      result[bit_base +: 4] <= cla_sum;
      carry                 <= cla_cout;
      if (last_step) begin
        result_cout <= cla_cout;
        idx         <= '0;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

  // Outputs: status flags from state, slice operands driven only while running.
  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    cla_a   = 4'h0;
    cla_b   = 4'h0;
    cla_cin = 1'b0;
    case (state)
      S_RUN: begin
        busy    = 1'b1;
        cla_a   = a_reg[bit_base +: 4];
        cla_b   = b_reg[bit_base +: 4];
        cla_cin = carry;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule
